sfx_mixer: RTL

SFX_MIXER -- requirements
Module: sfx_mixer

---
 rtl/sfx_mixer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sfx_mixer.sv
// sfx_mixer: multi-channel sound-effect mixer with a shared sample ROM.
//
// Once per output sample period (every CLK_DIV cycles) the mixer walks all
// channels in order.  For each channel it presents that channel's pointer
// on rom_addr for one cycle (ADDR), then accumulates the returned sample
// (DATA).  After the last channel it saturates the sum to SAMPLE_W bits
// and publishes it on ldata/rdata (OUT).
//
// Output strobe semantics: sample_strobe is high for exactly one cycle,
// the same cycle ldata/rdata first show the new frame value.  There is no
// back-pressure.  ldata/rdata hold their value until the next strobe.
//
// Ports:
//   Clk, Reset      - clock and synchronous active-high reset
//   trigger[N_CH]   - one-cycle start/restart pulse per channel
//   loop_en[N_CH]   - per-channel loop mode
//   start_addr      - packed per-channel first sample address
//   end_addr        - packed per-channel last sample address
//   mute            - forces the mixed output to zero
//   rom_addr        - shared ROM read address (valid during ADDR, else 0)
//   rom_data        - ROM data, one cycle after rom_addr
//   ldata, rdata    - mixed output sample (identical)
//   sample_strobe   - one-cycle pulse when ldata/rdata update
//   active[N_CH]    - per-channel playing flag
//   state_dbg       - current FSM state, for observation

module sfx_mixer #(
    parameter int N_CH     = 4,
    parameter int SAMPLE_W = 16,
    parameter int ADDR_W   = 14,
    parameter int CLK_DIV  = 6250
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [N_CH-1:0]          trigger,
    input  logic [N_CH-1:0]          loop_en,
    input  logic [N_CH*ADDR_W-1:0]   start_addr,
    input  logic [N_CH*ADDR_W-1:0]   end_addr,
    input  logic                     mute,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [SAMPLE_W-1:0]      rom_data,
    output logic [SAMPLE_W-1:0]      ldata,
    output logic [SAMPLE_W-1:0]      rdata,
    output logic                     sample_strobe,
    output logic [N_CH-1:0]          active,
    output logic [1:0]               state_dbg
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    // Headroom for summing N_CH full-scale samples without wrap.
    localparam int ACC_W = SAMPLE_W + $clog2(N_CH) + 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        ACC_W'((64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t                    state, state_n;
    logic [CNT_W-1:0]          div_cnt, div_n;
    logic [CH_W-1:0]           ch, ch_n;
    logic signed [ACC_W-1:0]   acc, acc_n, acc_sum, rom_ext;
    logic [ADDR_W-1:0]         ptr   [N_CH];
    logic [ADDR_W-1:0]         ptr_n [N_CH];
    logic [ADDR_W-1:0]         start_a [N_CH];
    logic [ADDR_W-1:0]         end_a   [N_CH];
    logic [N_CH-1:0]           active_q, active_n;
    logic [N_CH-1:0]           pending, pending_n;
    logic [SAMPLE_W-1:0]       ldata_q, ldata_n, sat_val;
    logic                      strobe_q, strobe_n;
    logic                      tick;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            start_a[i] = start_addr[i*ADDR_W +: ADDR_W];
            end_a[i]   = end_addr[i*ADDR_W +: ADDR_W];
        end
    end

    assign tick = (div_cnt == CNT_W'(CLK_DIV - 1));

    // Inactive channels contribute zero but still take their ADDR/DATA
    // slots, so the frame length is fixed regardless of activity.
    assign rom_ext = {{(ACC_W - SAMPLE_W){rom_data[SAMPLE_W-1]}}, rom_data};
    assign acc_sum = acc + (active_q[ch] ? rom_ext : '0);

    always_comb begin
        if (acc_sum > SAT_MAX) begin
            sat_val = SAT_MAX[SAMPLE_W-1:0];
        end else if (acc_sum < SAT_MIN) begin
            sat_val = SAT_MIN[SAMPLE_W-1:0];
        end else begin
            sat_val = acc_sum[SAMPLE_W-1:0];
        end
    end

    always_comb begin
        state_n   = state;
        div_n     = tick ? '0 : div_cnt + 1'b1;
        ch_n      = ch;
        acc_n     = acc;
        ptr_n     = ptr;
        active_n  = active_q;
        // Triggers are remembered until the next IDLE tick consumes them,
        // so a pulse that lands mid-frame is never lost.
        pending_n = pending | trigger;
        ldata_n   = ldata_q;
        strobe_n  = 1'b0;

        unique case (state)
            IDLE: begin
                if (tick) begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (pending[i] | trigger[i]) begin
                            ptr_n[i]    = start_a[i];
                            active_n[i] = 1'b1;
                        end
                    end
                    pending_n = '0;
                    ch_n      = '0;
                    acc_n     = '0;
                    state_n   = ADDR;
                end
            end
            ADDR: begin
                state_n = DATA;
            end
            DATA: begin
                acc_n = acc_sum;
                if (active_q[ch]) begin
                    // >= (not ==) so start > end plays one sample then ends.
                    if (ptr[ch] >= end_a[ch]) begin
                        if (loop_en[ch]) begin
                            ptr_n[ch] = start_a[ch];
                        end else begin
                            active_n[ch] = 1'b0;
                        end
                    end else begin
                        ptr_n[ch] = ptr[ch] + 1'b1;
                    end
                end
                if (ch == CH_W'(N_CH - 1)) begin
                    // Register the result on entry to OUT so the strobe and
                    // the new value appear together during OUT.
                    ldata_n  = mute ? '0 : sat_val;
                    strobe_n = 1'b1;
                    state_n  = OUT;
                end else begin
                    ch_n    = ch + 1'b1;
                    state_n = ADDR;
                end
            end
            OUT: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            ch       <= '0;
            acc      <= '0;
            active_q <= '0;
            pending  <= '0;
            ldata_q  <= '0;
            strobe_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                ptr[i] <= '0;
            end
        end else begin
            state    <= state_n;
            div_cnt  <= div_n;
            ch       <= ch_n;
            acc      <= acc_n;
            active_q <= active_n;
            pending  <= pending_n;
            ldata_q  <= ldata_n;
            strobe_q <= strobe_n;
            for (int i = 0; i < N_CH; i++) begin
                ptr[i] <= ptr_n[i];
            end
        end
    end

    assign rom_addr      = (state == ADDR) ? ptr[ch] : '0;
    assign ldata         = ldata_q;
    assign rdata         = ldata_q;
    assign sample_strobe = strobe_q;
    assign active        = active_q;
    assign state_dbg     = state;

endmodule
